// File: rtl/instr_ctrl_fsm.sv
// Instruction register plus Moore control FSM for the 8x16 register file and datapath.
// Captures a 16-bit instruction, decodes it and drives one datapath micro-step per cycle.
module instr_ctrl_fsm #(
  parameter logic [15:0] IR_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_DECODE = 3'd1,
    ST_WR_IMM = 3'd2,
    ST_GET_A  = 3'd3,
    ST_GET_B  = 3'd4,
    ST_ALU    = 3'd5,
    ST_WR_REG = 3'd6
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_IMM  = 2'b10;
  localparam logic [1:0] OP_REG  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;

  state_t      state, state_next;
  logic [15:0] ir;

  // Instruction field views.
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign rm     = ir[2:0];

  // Immediate and control fields follow IR in every state.
  assign shift  = ir[4:3];
  assign ALUop  = ir[12:11];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

  // Instruction register: captures only while idle in WAIT, so a busy load is ignored.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset)
      ir <= IR_RESET;
    else if (load && (state == ST_WAIT))
      ir <= in;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_WAIT;
    else
      state <= state_next;
  end

  // Next-state decode; DECODE sees the IR captured on the same edge that left WAIT.
  always_comb begin
    // NOTE: defaults first so no path leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      ST_WAIT:   if (s) state_next = ST_DECODE;
      ST_DECODE: begin
        if (opcode == OPC_MOV && op == OP_IMM)      state_next = ST_WR_IMM;
        else if (opcode == OPC_MOV && op == OP_REG) state_next = ST_GET_B;
        else if (opcode == OPC_ALU)                 state_next = ST_GET_A;
        else                                        state_next = ST_WAIT;
      end
      ST_WR_IMM: state_next = ST_WAIT;
      ST_GET_A:  state_next = ST_GET_B;
      ST_GET_B:  state_next = ST_ALU;
      ST_ALU:    state_next = (opcode == OPC_ALU && op == OP_CMP) ? ST_WAIT : ST_WR_REG;
      ST_WR_REG: state_next = ST_WAIT;
      default:   state_next = ST_WAIT;
    endcase
  end

  // Moore outputs from state only; strobes are suppressed while reset is high.
  always_comb begin
    w        = 1'b0;
    readnum  = 3'b000;
    writenum = 3'b000;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    vsel     = 1'b0;
    unique case (state)
      ST_WAIT:   w = 1'b1;
      ST_DECODE: ;
      ST_WR_IMM: begin
        writenum = rn;
        vsel     = 1'b1;
        write    = !reset;
      end
      ST_GET_A: begin
        readnum = rn;
        loada   = !reset;
      end
      ST_GET_B: begin
        readnum = rm;
        loadb   = !reset;
      end
      ST_ALU: begin
        loadc = !reset;
        asel  = (opcode == OPC_MOV);
        loads = !reset && (opcode == OPC_ALU) && (op == OP_CMP);
      end
      ST_WR_REG: begin
        writenum = rd;
        write    = !reset;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_ctrl_fsm.sv
// Directed self-checking bench for instr_ctrl_fsm.
module tb_instr_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset, s, load;
  logic [15:0] in;
  logic        w, write, loada, loadb, loadc, loads, asel, vsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, ALUop;
  logic [15:0] sximm8, sximm5;

  integer checks = 0;
  integer errors = 0;

  instr_ctrl_fsm #(.IR_RESET(16'h0000)) dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
    .w(w), .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .vsel(vsel), .shift(shift), .ALUop(ALUop),
    .sximm8(sximm8), .sximm5(sximm5)
  );

  always #5 clk = ~clk;

  // {w, readnum, writenum, write, loada, loadb, loadc, loads, asel, vsel}
  logic [13:0] obs;
  assign obs = {w, readnum, writenum, write, loada, loadb, loadc, loads, asel, vsel};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; s = 1'b1; load = 1'b1; in = 16'hFFFF;
    tick();
    tick();
    checks++;
    if (obs !== {1'b1, 3'd0, 3'd0, 7'b0000000}) begin
      errors++; $display("FAIL reset_outputs got %h exp %h", obs, {1'b1, 3'd0, 3'd0, 7'b0000000});
    end
    checks++;
    if (sximm8 !== 16'h0000 || sximm5 !== 16'h0000) begin
      errors++; $display("FAIL reset_ir got %h/%h exp 0000/0000", sximm8, sximm5);
    end
    reset = 1'b0; s = 1'b0; load = 1'b0;
    tick();
    checks++;
    if (obs !== {1'b1, 3'd0, 3'd0, 7'b0000000}) begin
      errors++; $display("FAIL reset_s_ignored got %h exp %h", obs, {1'b1, 3'd0, 3'd0, 7'b0000000});
    end
  endtask

  task automatic test_mov_imm();
    load = 1'b1; in = 16'hD2F6;
    tick();
    load = 1'b0; s = 1'b1;
    tick();
    s = 1'b0;
    checks++;
    if (obs !== {1'b0, 3'd0, 3'd0, 7'b0000000}) begin
      errors++; $display("FAIL movi_decode got %h exp %h", obs, {1'b0, 3'd0, 3'd0, 7'b0000000});
    end
    tick();
    checks++;
    if (obs !== {1'b0, 3'd0, 3'd2, 7'b1000001}) begin
      errors++; $display("FAIL movi_wr_imm got %h exp %h", obs, {1'b0, 3'd0, 3'd2, 7'b1000001});
    end
    checks++;
    if (sximm8 !== 16'hFFF6) begin
      errors++; $display("FAIL movi_sximm8 got %h exp FFF6", sximm8);
    end
    tick();
    checks++;
    if (obs !== {1'b1, 3'd0, 3'd0, 7'b0000000}) begin
      errors++; $display("FAIL movi_wait got %h exp %h", obs, {1'b1, 3'd0, 3'd0, 7'b0000000});
    end
  endtask

  task automatic test_add();
    load = 1'b1; in = 16'hA162;
    tick();
    load = 1'b0; s = 1'b1;
    tick();
    s = 1'b0;
    tick();
    checks++;
    if (obs !== {1'b0, 3'd1, 3'd0, 7'b0100000}) begin
      errors++; $display("FAIL add_get_a got %h exp %h", obs, {1'b0, 3'd1, 3'd0, 7'b0100000});
    end
    tick();
    checks++;
    if (obs !== {1'b0, 3'd2, 3'd0, 7'b0010000}) begin
      errors++; $display("FAIL add_get_b got %h exp %h", obs, {1'b0, 3'd2, 3'd0, 7'b0010000});
    end
    tick();
    checks++;
    if (obs !== {1'b0, 3'd0, 3'd0, 7'b0001000}) begin
      errors++; $display("FAIL add_alu got %h exp %h", obs, {1'b0, 3'd0, 3'd0, 7'b0001000});
    end
    tick();
    checks++;
    if (obs !== {1'b0, 3'd0, 3'd3, 7'b1000000}) begin
      errors++; $display("FAIL add_wr_reg got %h exp %h", obs, {1'b0, 3'd0, 3'd3, 7'b1000000});
    end
    tick();
    checks++;
    if (obs !== {1'b1, 3'd0, 3'd0, 7'b0000000}) begin
      errors++; $display("FAIL add_wait got %h exp %h", obs, {1'b1, 3'd0, 3'd0, 7'b0000000});
    end
  endtask

  task automatic test_cmp();
    load = 1'b1; in = 16'hA902;
    tick();
    load = 1'b0; s = 1'b1;
    tick();
    s = 1'b0;
    tick();
    checks++;
    if (obs !== {1'b0, 3'd1, 3'd0, 7'b0100000}) begin
      errors++; $display("FAIL cmp_get_a got %h exp %h", obs, {1'b0, 3'd1, 3'd0, 7'b0100000});
    end
    tick();
    checks++;
    if (obs !== {1'b0, 3'd2, 3'd0, 7'b0010000}) begin
      errors++; $display("FAIL cmp_get_b got %h exp %h", obs, {1'b0, 3'd2, 3'd0, 7'b0010000});
    end
    tick();
    checks++;
    if (obs !== {1'b0, 3'd0, 3'd0, 7'b0001100}) begin
      errors++; $display("FAIL cmp_alu got %h exp %h", obs, {1'b0, 3'd0, 3'd0, 7'b0001100});
    end
    checks++;
    if (ALUop !== 2'b01) begin
      errors++; $display("FAIL cmp_aluop got %b exp 01", ALUop);
    end
    tick();
    checks++;
    if (obs !== {1'b1, 3'd0, 3'd0, 7'b0000000}) begin
      errors++; $display("FAIL cmp_wait got %h exp %h", obs, {1'b1, 3'd0, 3'd0, 7'b0000000});
    end
  endtask

  task automatic test_mov_reg();
    load = 1'b1; in = 16'hC0A8;
    tick();
    load = 1'b0; s = 1'b1;
    tick();
    s = 1'b0;
    load = 1'b1; in = 16'hFFFF;   // busy: must be ignored
    tick();
    checks++;
    if (obs !== {1'b0, 3'd0, 3'd0, 7'b0010000}) begin
      errors++; $display("FAIL movr_get_b got %h exp %h", obs, {1'b0, 3'd0, 3'd0, 7'b0010000});
    end
    tick();
    checks++;
    if (obs !== {1'b0, 3'd0, 3'd0, 7'b0001010}) begin
      errors++; $display("FAIL movr_alu got %h exp %h", obs, {1'b0, 3'd0, 3'd0, 7'b0001010});
    end
    tick();
    load = 1'b0;
    checks++;
    if (obs !== {1'b0, 3'd0, 3'd5, 7'b1000000}) begin
      errors++; $display("FAIL movr_wr_reg got %h exp %h", obs, {1'b0, 3'd0, 3'd5, 7'b1000000});
    end
    checks++;
    if (shift !== 2'b01 || ALUop !== 2'b00 || sximm8 !== 16'hFFA8 || sximm5 !== 16'h0008) begin
      errors++; $display("FAIL movr_ir_hold got %b %b %h %h exp 01 00 FFA8 0008",
                         shift, ALUop, sximm8, sximm5);
    end
    tick();
    checks++;
    if (obs !== {1'b1, 3'd0, 3'd0, 7'b0000000}) begin
      errors++; $display("FAIL movr_wait got %h exp %h", obs, {1'b1, 3'd0, 3'd0, 7'b0000000});
    end
  endtask

  task automatic test_reset_mid_and_illegal();
    load = 1'b1; in = 16'hA162;
    tick();
    load = 1'b0; s = 1'b1;
    tick();
    s = 1'b0;
    tick(); tick(); tick(); tick();   // GET_A, GET_B, ALU, WR_REG
    reset = 1'b1;
    #1;
    checks++;
    if (write !== 1'b0 || loada !== 1'b0 || loadb !== 1'b0 || loadc !== 1'b0 || loads !== 1'b0) begin
      errors++; $display("FAIL rst_mid_strobes got %b%b%b%b%b exp 00000",
                         write, loada, loadb, loadc, loads);
    end
    tick();
    reset = 1'b0;
    checks++;
    if (obs !== {1'b1, 3'd0, 3'd0, 7'b0000000} || sximm8 !== 16'h0000) begin
      errors++; $display("FAIL rst_mid_wait got %h/%h exp %h/0000",
                         obs, sximm8, {1'b1, 3'd0, 3'd0, 7'b0000000});
    end
    load = 1'b1; in = 16'hE000;
    tick();
    load = 1'b0; s = 1'b1;
    tick();
    s = 1'b0;
    checks++;
    if (obs !== {1'b0, 3'd0, 3'd0, 7'b0000000}) begin
      errors++; $display("FAIL illegal_decode got %h exp %h", obs, {1'b0, 3'd0, 3'd0, 7'b0000000});
    end
    tick();
    checks++;
    if (obs !== {1'b1, 3'd0, 3'd0, 7'b0000000}) begin
      errors++; $display("FAIL illegal_wait got %h exp %h", obs, {1'b1, 3'd0, 3'd0, 7'b0000000});
    end
  endtask

  task automatic test_back_to_back();
    load = 1'b1; s = 1'b1; in = 16'hD2F6;
    tick();
    load = 1'b0;
    checks++;
    if (obs !== {1'b0, 3'd0, 3'd0, 7'b0000000} || sximm8 !== 16'hFFF6) begin
      errors++; $display("FAIL b2b_decode got %h/%h exp %h/FFF6",
                         obs, sximm8, {1'b0, 3'd0, 3'd0, 7'b0000000});
    end
    tick();
    checks++;
    if (obs !== {1'b0, 3'd0, 3'd2, 7'b1000001}) begin
      errors++; $display("FAIL b2b_wr_imm1 got %h exp %h", obs, {1'b0, 3'd0, 3'd2, 7'b1000001});
    end
    tick();
    checks++;
    if (obs !== {1'b1, 3'd0, 3'd0, 7'b0000000}) begin
      errors++; $display("FAIL b2b_wait got %h exp %h", obs, {1'b1, 3'd0, 3'd0, 7'b0000000});
    end
    tick();
    checks++;
    if (obs !== {1'b0, 3'd0, 3'd0, 7'b0000000}) begin
      errors++; $display("FAIL b2b_redecode got %h exp %h", obs, {1'b0, 3'd0, 3'd0, 7'b0000000});
    end
    s = 1'b0;
    tick();
    checks++;
    if (obs !== {1'b0, 3'd0, 3'd2, 7'b1000001}) begin
      errors++; $display("FAIL b2b_wr_imm2 got %h exp %h", obs, {1'b0, 3'd0, 3'd2, 7'b1000001});
    end
    tick();
    checks++;
    if (obs !== {1'b1, 3'd0, 3'd0, 7'b0000000}) begin
      errors++; $display("FAIL b2b_final got %h exp %h", obs, {1'b1, 3'd0, 3'd0, 7'b0000000});
    end
  endtask

  initial begin
    reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0000;
    test_reset();
    test_mov_imm();
    test_add();
    test_cmp();
    test_mov_reg();
    test_reset_mid_and_illegal();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
